// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle ARM control unit.
// Holds the main FSM state encoding, the ALU control codes, the instruction
// op-field codes, the data-processing command codes and the datapath mux-select
// values used by mainfsm and aludec.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } statetype;

    // ALU control codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instruction op field, bits [27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing command, bits [24:21]
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Memory address select
    localparam logic       ADR_PC  = 1'b0;
    localparam logic       ADR_ALU = 1'b1;

    // ALU A select
    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALU B select
    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/aludec.sv
// aludec: combinational ALU decoder.
// Ports:
//   iALUOp       in  1  1 = data-processing execute, 0 = plain address/PC add
//   iFunct       in  5  instruction bits [24:20]: [4:1] command, [0] S flag
//   oALUControl  out 2  ALU operation (ADD/SUB/AND/ORR)
//   oFlagW       out 2  raw flag-write enables: [1] = N,Z; [0] = C,V
module aludec
    import ctrl_pkg::*;
(
    input  logic       iALUOp,
    input  logic [4:0] iFunct,
    output logic [1:0] oALUControl,
    output logic [1:0] oFlagW
);

    always_comb begin
        oALUControl = ALU_ADD;
        oFlagW      = 2'b00;
        if (iALUOp) begin
            // Logical ops leave C,V untouched; unknown commands fall back to
            // ADD and never write flags.
            case (iFunct[4:1])
                CMD_ADD: begin
                    oALUControl = ALU_ADD;
                    oFlagW      = {iFunct[0], iFunct[0]};
                end
                CMD_SUB: begin
                    oALUControl = ALU_SUB;
                    oFlagW      = {iFunct[0], iFunct[0]};
                end
                CMD_AND: begin
                    oALUControl = ALU_AND;
                    oFlagW      = {iFunct[0], 1'b0};
                end
                CMD_ORR: begin
                    oALUControl = ALU_ORR;
                    oFlagW      = {iFunct[0], 1'b0};
                end
                default: begin
                    oALUControl = ALU_ADD;
                    oFlagW      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: Moore control FSM for the multicycle ARM datapath.
// Sequences fetch, decode, execute, memory and writeback, and produces the
// raw (unconditioned) strobes consumed by the conditional-logic stage.
// Ports:
//   iClk, iReset (async, active-low)
//   iOp[1:0], iFunct[5:0], iRd[3:0]  instruction fields from the IR
//   oIRWrite, oNextPC, oAdrSrc, oALUSrcA, oALUSrcB, oResultSrc  datapath controls
//   oALUControl, oFlagW                                         from aludec
//   oRegW, oMemW, oPCS                                          raw write/PC strobes
module mainfsm
    import ctrl_pkg::*;
(
    input  logic       iClk,
    input  logic       iReset,
    input  logic [1:0] iOp,
    input  logic [5:0] iFunct,
    input  logic [3:0] iRd,
    output logic       oIRWrite,
    output logic       oNextPC,
    output logic       oAdrSrc,
    output logic [1:0] oALUSrcA,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oResultSrc,
    output logic [1:0] oALUControl,
    output logic [1:0] oFlagW,
    output logic       oRegW,
    output logic       oMemW,
    output logic       oPCS
);

    statetype   state, state_next;
    logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] flag_w;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) state <= FETCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        oAdrSrc    = ADR_PC;
        oALUSrcA   = SRCA_RN;
        oALUSrcB   = SRCB_RM;
        oResultSrc = RES_ALUOUT;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (state)
            FETCH: begin
                state_next = DECODE;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                oALUSrcA   = SRCA_PC;
                oALUSrcB   = SRCB_FOUR;
                oResultSrc = RES_ALU;
            end
            DECODE: begin
                // Computes PC+8 for a later R15 read; op 11 returns to FETCH.
                oALUSrcA   = SRCA_PC;
                oALUSrcB   = SRCB_FOUR;
                oResultSrc = RES_ALU;
                case (iOp)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = iFunct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                state_next = iFunct[0] ? MEMREAD : MEMWRITE;
                oALUSrcB   = SRCB_EXTIMM;
            end
            MEMREAD: begin
                state_next = MEMWB;
                oAdrSrc    = ADR_ALU;
            end
            MEMWB: begin
                oResultSrc = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                oAdrSrc = ADR_ALU;
                mem_w   = 1'b1;
            end
            EXECUTER: begin
                state_next = ALUWB;
                alu_op     = 1'b1;
            end
            EXECUTEI: begin
                state_next = ALUWB;
                oALUSrcB   = SRCB_EXTIMM;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                oALUSrcA   = SRCA_ALUOUT;
                oALUSrcB   = SRCB_EXTIMM;
                oResultSrc = RES_ALU;
                branch     = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    aludec u_aludec (
        .iALUOp      (alu_op),
        .iFunct      (iFunct[4:0]),
        .oALUControl (oALUControl),
        .oFlagW      (flag_w)
    );

    // While reset is held the state already reads FETCH, but its strobes must
    // stay quiet, so every strobe is masked directly by iReset.
    assign oIRWrite = ir_write & iReset;
    assign oNextPC  = next_pc & iReset;
    assign oRegW    = reg_w & iReset;
    assign oMemW    = mem_w & iReset;
    assign oFlagW   = flag_w & {2{iReset}};
    assign oPCS     = (branch | (reg_w & (iRd == 4'd15))) & iReset;

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle control unit for the ARM datapath: a Moore state machine that sequences fetch, decode, execute, memory and writeback. It also contains an ALU decoder. It sits directly upstream of the conditional-logic stage and produces that stage's raw, unconditioned strobes: register write, memory write, flag-write enables and PC-source request. It also drives every datapath mux select and write enable.

## Interface
Parameters: none.

Ports:
- iClk  in  1  system clock, rising edge
- iReset  in  1  asynchronous, active-low reset
- iOp  in  2  instruction bits [27:26], taken from the instruction register
- iFunct  in  6  instruction bits [25:20]; bit 5 = I (immediate), bit 0 = S (set flags) or L (load)
- iRd  in  4  instruction bits [15:12]
- oIRWrite  out  1  instruction-register load enable
- oNextPC  out  1  PC update enable (unconditional part)
- oAdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result
- oALUSrcA  out  2  ALU A select: 00 = Rn, 01 = PC, 10 = ALUOut
- oALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4
- oResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result
- oALUControl  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR
- oFlagW  out  2  raw flag-write enables: [1] = N,Z; [0] = C,V
- oRegW, oMemW  out  1 each  raw register-file and memory write strobes
- oPCS  out  1  raw PC-source request: oBranch, or (oRegW and iRd == 15)

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.

Transitions:
- FETCH → DECODE.
- DECODE, by iOp:
  - 01 → MEMADR
  - 00 with iFunct[5] = 0 → EXECUTER
  - 00 with iFunct[5] = 1 → EXECUTEI
  - 10 → BRANCH
  - 11 (illegal) → FETCH, with no strobe asserted
- MEMADR → MEMREAD if iFunct[0] = 1, else → MEMWRITE.
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECUTER and EXECUTEI → ALUWB → FETCH.
- BRANCH → FETCH.

Moore outputs per state (anything not listed is 0):
- FETCH: IRWrite = 1, NextPC = 1, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
- DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
- MEMADR: ALUSrcB = 01.
- MEMREAD: AdrSrc = 1.
- MEMWB: ResultSrc = 01, RegW = 1.
- MEMWRITE: AdrSrc = 1, MemW = 1.
- EXECUTER: ALUOp = 1.
- EXECUTEI: ALUSrcB = 01, ALUOp = 1.
- ALUWB: RegW = 1.
- BRANCH: ALUSrcA = 10, ALUSrcB = 01, ResultSrc = 10, Branch = 1.

ALU decoder (combinational, driven by ALUOp and iFunct):
- ALUOp = 0: ALUControl = ADD, FlagW = 00.
- ALUOp = 1, command iFunct[4:1]:
  - 0100 → ADD
  - 0010 → SUB
  - 0000 → AND
  - 1100 → ORR
  - any other command → ADD with FlagW = 00
- FlagW[1] = iFunct[0].
- FlagW[0] = iFunct[0] and ALUControl is ADD or SUB.

Output semantics:
- oFlagW is nonzero only in EXECUTER or EXECUTEI.
- All strobes are raw; gating by the condition result is done downstream.

## Timing
- Reset: while iReset = 0, the state is FETCH and every strobe is forced to 0 (IRWrite, NextPC, RegW, MemW, PCS, FlagW). Mux selects show FETCH values; oALUControl = 00.
- First FETCH strobes appear in the cycle after iReset rises.
- Reset asserted mid-instruction aborts it immediately; no write strobe is asserted after the reset edge.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - branch: 3
  - data-processing: 4
  - STR: 4
  - LDR: 5
  - illegal iOp: 2
- iOp, iFunct and iRd are sampled only outside FETCH. They must be stable from DECODE until the instruction returns to FETCH.
- All outputs are glitch-free functions of the registered state plus those stable inputs. There is no combinational path from the inputs to the state register except through next-state logic.

## Structure
- Shared package ctrl_pkg:
  - state enum type statetype
  - ALU control constants ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR
  - op constants OP_DP = 00, OP_MEM = 01, OP_BR = 10
  - mux-select constants
- Sub-module aludec: combinational ALU decoder; inputs ALUOp and iFunct; outputs oALUControl and oFlagW.
- The state register is the only sequential element.

## Test plan
- Reset held low for 3 cycles, then released with iOp = 10 → all strobes 0 during reset. Next cycle: FETCH with IRWrite = 1, NextPC = 1. Then DECODE, then BRANCH with oPCS = 1 and ALUSrcA = 10, then FETCH.
- ADDS R1,R2,R3 (iOp = 00, iFunct = 001001, iRd = 1) → EXECUTER shows ALUControl = 00, FlagW = 11. ALUWB shows RegW = 1, PCS = 0. 4 cycles total.
- ANDS immediate (iOp = 00, iFunct = 100001) → EXECUTEI shows ALUSrcB = 01, ALUControl = 10, FlagW = 10.
- LDR (iOp = 01, iFunct = 011001) → MEMADR, MEMREAD (AdrSrc = 1), MEMWB (ResultSrc = 01, RegW = 1). 5 cycles. With iRd = 15: oPCS = 1 in MEMWB.
- STR (iFunct[0] = 0) → MEMWRITE with MemW = 1, AdrSrc = 1. Reset pulsed during MEMADR → MemW never asserted; restart in FETCH.
- iOp = 11 → DECODE → FETCH with no RegW, MemW or PCS. An unsupported command (e.g. 1111) in EXECUTER → FlagW = 00.
